// File: rtl/aes_pkg.sv
// rtl/aes_pkg.sv - AES round constants, FSM encoding, inverse S-box and GF(2^8) helpers
package aes_pkg;

   localparam int NR = 10;
   localparam int NK = 4;
   localparam int N  = 128;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_ROUND = 2'd1,
      ST_LAST  = 2'd2,
      ST_DONE  = 2'd3
   } fsm_t;

   // Entry for input byte x sits at bits [(255-x)*8 +: 8], i.e. byte 0x00 is the MSB byte.
   localparam logic [2047:0] INV_SBOX_TBL = {
      128'h52096ad53036a538bf40a39e81f3d7fb,
      128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e,
      128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692,
      128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506,
      128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673,
      128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b,
      128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f,
      128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961,
      128'h172b047eba77d626e169146355210c7d
   };

   function automatic logic [7:0] inv_sbox(input logic [7:0] x);
      return INV_SBOX_TBL[{~x, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p;
      logic [7:0] aa;
      logic [7:0] bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = xtime(aa);
         bb = bb >> 1;
      end
      return p;
   endfunction

endpackage

// File: rtl/aes_inv_round.sv
// rtl/aes_inv_round.sv - combinational AES inverse round; last=1 skips InvMixColumns
module aes_inv_round (
   input  logic [127:0] state_in,
   input  logic [127:0] rk,
   input  logic         last,
   output logic [127:0] state_out
);
   import aes_pkg::*;

   logic [127:0] sub_v;
   logic [127:0] ark_v;
   logic [127:0] mix_v;

   function automatic logic [31:0] inv_mix_col(input logic [31:0] col);
      logic [7:0] a0, a1, a2, a3;
      a0 = col[31:24];
      a1 = col[23:16];
      a2 = col[15:8];
      a3 = col[7:0];
      return {gf_mul(8'h0e, a0) ^ gf_mul(8'h0b, a1) ^ gf_mul(8'h0d, a2) ^ gf_mul(8'h09, a3),
              gf_mul(8'h09, a0) ^ gf_mul(8'h0e, a1) ^ gf_mul(8'h0b, a2) ^ gf_mul(8'h0d, a3),
              gf_mul(8'h0d, a0) ^ gf_mul(8'h09, a1) ^ gf_mul(8'h0e, a2) ^ gf_mul(8'h0b, a3),
              gf_mul(8'h0b, a0) ^ gf_mul(8'h0d, a1) ^ gf_mul(8'h09, a2) ^ gf_mul(8'h0e, a3)};
   endfunction

   // Byte k = row + 4*col lives at [(15-k)*8 +: 8]; row r rotates right by r columns.
   always_comb begin
      sub_v = '0;
      for (int c = 0; c < 4; c++) begin
         for (int r = 0; r < 4; r++) begin
            sub_v[(15 - (r + 4 * c)) * 8 +: 8] =
               inv_sbox(state_in[(15 - (r + 4 * ((c - r + 4) % 4))) * 8 +: 8]);
         end
      end
   end

   assign ark_v = sub_v ^ rk;

   always_comb begin
      mix_v = '0;
      for (int c = 0; c < 4; c++) begin
         mix_v[(3 - c) * 32 +: 32] = inv_mix_col(ark_v[(3 - c) * 32 +: 32]);
      end
   end

   assign state_out = last ? ark_v : mix_v;

endmodule

// File: rtl/aes_inv_cipher_core.sv
// rtl/aes_inv_cipher_core.sv - iterative AES-128 inverse cipher, one round per clock
// Optional build macro AES_DEC_ZEROIZE_EN clears the state after output and masks dout when idle.
module aes_inv_cipher_core (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] din,
   output logic [3:0]   rk_idx,
   input  logic [127:0] rk_in,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] dout,
   output logic         busy
);
   import aes_pkg::*;

   localparam logic [3:0] RK_FIRST = 4'(NR);

   fsm_t         fsm;
   fsm_t         fsm_nxt;
   logic [3:0]   ctr;
   logic [127:0] state_q;
   logic [127:0] round_out;
   logic         last_rnd;
   logic         accept;
   logic         release_blk;

   assign last_rnd = (fsm == ST_LAST);

   aes_inv_round u_round (
      .state_in  (state_q),
      .rk        (rk_in),
      .last      (last_rnd),
      .state_out (round_out)
   );

   // rk_idx depends only on fsm/ctr so a key RAM can be addressed without input loops.
   always_comb begin
      fsm_nxt   = fsm;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      busy      = 1'b0;
      rk_idx    = RK_FIRST;
      case (fsm)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid) fsm_nxt = ST_ROUND;
         end
         ST_ROUND: begin
            busy   = 1'b1;
            rk_idx = ctr;
            if (ctr == 4'd1) fsm_nxt = ST_LAST;
         end
         ST_LAST: begin
            busy    = 1'b1;
            rk_idx  = 4'd0;
            fsm_nxt = ST_DONE;
         end
         ST_DONE: begin
            busy      = 1'b1;
            out_valid = 1'b1;
            rk_idx    = 4'd0;
            if (out_ready) fsm_nxt = ST_IDLE;
         end
         default: fsm_nxt = ST_IDLE;
      endcase
   end

   assign accept      = in_valid && in_ready;
   assign release_blk = out_valid && out_ready;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         fsm     <= ST_IDLE;
         ctr     <= RK_FIRST;
         state_q <= '0;
      end else begin
         fsm <= fsm_nxt;
         case (fsm)
            ST_IDLE: begin
               if (accept) begin
                  state_q <= din ^ rk_in;
                  ctr     <= RK_FIRST - 4'd1;
               end
            end
            ST_ROUND: begin
               state_q <= round_out;
               ctr     <= ctr - 4'd1;
            end
            ST_LAST: state_q <= round_out;
            ST_DONE: begin
               if (release_blk) begin
                  ctr <= RK_FIRST;
`ifdef AES_DEC_ZEROIZE_EN
                  state_q <= '0;
`endif
               end
            end
            default: ;
         endcase
      end
   end

`ifdef AES_DEC_ZEROIZE_EN
   assign dout = out_valid ? state_q : '0;
`else
   assign dout = state_q;
`endif

endmodule

// File: tb/tb_aes_inv_cipher_core.sv
// tb/tb_aes_inv_cipher_core.sv - directed FIPS-197 vector bench for aes_inv_cipher_core
module tb_aes_inv_cipher_core;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] din;
   logic [3:0]   rk_idx;
   logic [127:0] rk_in;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] dout;
   logic         busy;
   logic         key_sel;

   int tests;
   int fails;

   logic [127:0] ks_b [0:10];
   logic [127:0] ks_c [0:10];

   localparam logic [127:0] CT_B = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_B = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [127:0] CT_C = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] PT_C = 128'h00112233445566778899aabbccddeeff;

   aes_inv_cipher_core dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .din       (din),
      .rk_idx    (rk_idx),
      .rk_in     (rk_in),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .dout      (dout),
      .busy      (busy)
   );

   // Key RAM model: answers rk_idx combinationally from the selected schedule.
   assign rk_in = (rk_idx > 4'd10) ? 128'h0 : (key_sel ? ks_c[rk_idx] : ks_b[rk_idx]);

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Starts at a negedge in IDLE; returns at the negedge after out_valid should have risen.
   task automatic do_block(input logic [127:0] ct, input logic sel, input logic [127:0] pt,
                           input logic rdy);
      key_sel   = sel;
      din       = ct;
      in_valid  = 1'b1;
      out_ready = rdy;
      chk("in_ready_idle", 128'(in_ready), 128'(1));
      for (int k = 0; k <= 10; k++) begin
         chk($sformatf("rk_idx_k%0d", k), 128'(rk_idx), 128'(10 - k));
         chk($sformatf("out_valid_low_k%0d", k), 128'(out_valid), 128'(0));
         @(negedge clk);
         if (k == 0) begin
            in_valid = 1'b0;
            din      = '1;
            chk("busy_after_accept", 128'(busy), 128'(1));
         end
      end
      chk("out_valid_done", 128'(out_valid), 128'(1));
      chk("dout_done", dout, pt);
      chk("in_ready_done", 128'(in_ready), 128'(0));
   endtask

   initial begin
      tests     = 0;
      fails     = 0;
      ks_b = '{128'h2b7e151628aed2a6abf7158809cf4f3c, 128'ha0fafe1788542cb123a339392a6c7605,
               128'hf2c295f27a96b9435935807a7359f67f, 128'h3d80477d4716fe3e1e237e446d7a883b,
               128'hef44a541a8525b7fb671253bdb0bad00, 128'hd4d1c6f87c839d87caf2b8bc11f915bc,
               128'h6d88a37a110b3efddbf98641ca0093fd, 128'h4e54f70e5f5fc9f384a64fb24ea6dc4f,
               128'head27321b58dbad2312bf5607f8d292f, 128'hac7766f319fadc2128d12941575c006e,
               128'hd014f9a8c9ee2589e13f0cc8b6630ca6};
      ks_c = '{128'h000102030405060708090a0b0c0d0e0f, 128'hd6aa74fdd2af72fadaa678f1d6ab76fe,
               128'hb692cf0b643dbdf1be9bc5006830b3fe, 128'hb6ff744ed2c2c9bf6c590cbf0469bf41,
               128'h47f7f7bc95353e03f96c32bcfd058dfd, 128'h3caaa3e8a99f9deb50f3af57adf622aa,
               128'h5e390f7df7a69296a7553dc10aa31f6b, 128'h14f9701ae35fe28c440adf4d4ea9c026,
               128'h47438735a41c65b9e016baf4aebf7ad2, 128'h549932d1f08557681093ed9cbe2c974e,
               128'h13111d7fe3944a17f307a78b4d2b30c5};
      rst       = 1'b1;
      in_valid  = 1'b0;
      out_ready = 1'b0;
      din       = '0;
      key_sel   = 1'b0;

      repeat (2) @(negedge clk);
      chk("rst_out_valid", 128'(out_valid), 128'(0));
      chk("rst_busy", 128'(busy), 128'(0));
      chk("rst_dout", dout, 128'h0);
      chk("rst_rk_idx", 128'(rk_idx), 128'(10));
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", 128'(in_ready), 128'(1));

      // App.B vector with 5 cycles of backpressure and an ignored second request.
      do_block(CT_B, 1'b0, PT_B, 1'b0);
      in_valid = 1'b1;
      din      = CT_C;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         chk("bp_out_valid", 128'(out_valid), 128'(1));
         chk("bp_dout", dout, PT_B);
         chk("bp_in_ready", 128'(in_ready), 128'(0));
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      chk("hs_out_valid", 128'(out_valid), 128'(0));
      chk("hs_in_ready", 128'(in_ready), 128'(1));
      chk("hs_busy", 128'(busy), 128'(0));
      chk("hs_rk_idx", 128'(rk_idx), 128'(10));
`ifdef AES_DEC_ZEROIZE_EN
      chk("hs_dout_zero", dout, 128'h0);
      chk("hs_state_zero", dut.state_q, 128'h0);
`else
      chk("hs_dout_kept", dout, PT_B);
`endif

      // App.C.1 vector with out_ready held high throughout.
      do_block(CT_C, 1'b1, PT_C, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      chk("c1_hs_out_valid", 128'(out_valid), 128'(0));
      chk("c1_hs_in_ready", 128'(in_ready), 128'(1));

      // Asynchronous reset in the middle of round processing.
      key_sel  = 1'b0;
      din      = CT_B;
      in_valid = 1'b1;
      @(negedge clk);
      in_valid = 1'b0;
      repeat (5) @(negedge clk);
      chk("mid_busy_before_rst", 128'(busy), 128'(1));
      #2 rst = 1'b1;
      #1;
      chk("mid_rst_out_valid", 128'(out_valid), 128'(0));
      chk("mid_rst_busy", 128'(busy), 128'(0));
      chk("mid_rst_dout", dout, 128'h0);
      chk("mid_rst_rk_idx", 128'(rk_idx), 128'(10));
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_post_in_ready", 128'(in_ready), 128'(1));
      chk("mid_post_out_valid", 128'(out_valid), 128'(0));

      do_block(CT_B, 1'b0, PT_B, 1'b1);
      @(negedge clk);
      out_ready = 1'b0;
      chk("final_in_ready", 128'(in_ready), 128'(1));

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
